// File: rtl/blink_pkg.sv
// Shared types and defaults for the blink sequencer.
// Mode codes, colour indices and counter sizing helpers.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CYCLE = 2'd3
    } mode_e;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    localparam int DEBOUNCE_CYC_DEF    = 240000;
    localparam int HALF_PERIOD_CYC_DEF = 6000000;

    // A counter only ever holds 0..n-1, so $clog2(n) bits suffice.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        unique case (m)
            MODE_OFF:   r = MODE_SOLID;
            MODE_SOLID: r = MODE_BLINK;
            MODE_BLINK: r = MODE_CYCLE;
            MODE_CYCLE: r = MODE_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer.
// Emits a one-cycle press pulse on each accepted 0->1 level.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Any cycle matching the accepted level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/blink_sequencer.sv
// Push-button mode sequencer driving an RGB LED.
// Modes: OFF, SOLID blue, BLINK blue, CYCLE R/G/B.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
    parameter int HALF_PERIOD_CYC = HALF_PERIOD_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       led_off,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic [1:0] mode
);

    localparam int PW = cnt_width(HALF_PERIOD_CYC);
    localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD_CYC - 1);

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .press(press)
    );

    mode_e         mode_q;
    mode_e         mode_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          phase_q;
    logic          phase_d;
    logic [1:0]    col_q;
    logic [1:0]    col_d;
    logic          led_off_q;
    logic          led_off_d;
    logic          red_q;
    logic          red_d;
    logic          green_q;
    logic          green_d;
    logic          blue_q;
    logic          blue_d;

    always_comb begin
        mode_d  = mode_q;
        pcnt_d  = pcnt_q + PW'(1);
        phase_d = phase_q;
        col_d   = col_q;
        // A press wins over a coincident phase wrap.
        if (press) begin
            mode_d  = next_mode(mode_q);
            pcnt_d  = '0;
            phase_d = 1'b0;
            col_d   = COL_R;
        end else if (pcnt_q == PH_LAST) begin
            pcnt_d  = '0;
            phase_d = ~phase_q;
            if (mode_q == MODE_CYCLE) begin
                col_d = (col_q == COL_B) ? COL_R : col_q + 2'd1;
            end
        end
    end

    // Outputs are decoded from next state so they register with it.
    always_comb begin
        led_off_d = 1'b1;
        red_d     = 1'b0;
        green_d   = 1'b0;
        blue_d    = 1'b0;
        unique case (mode_d)
            MODE_OFF: begin
                led_off_d = 1'b1;
            end
            MODE_SOLID: begin
                led_off_d = 1'b0;
                blue_d    = 1'b1;
            end
            MODE_BLINK: begin
                led_off_d = phase_d;
                blue_d    = ~phase_d;
            end
            MODE_CYCLE: begin
                led_off_d = 1'b0;
                red_d     = (col_d == COL_R);
                green_d   = (col_d == COL_G);
                blue_d    = (col_d == COL_B);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_OFF;
            pcnt_q    <= '0;
            phase_q   <= 1'b0;
            col_q     <= COL_R;
            led_off_q <= 1'b1;
            red_q     <= 1'b0;
            green_q   <= 1'b0;
            blue_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pcnt_q    <= pcnt_d;
            phase_q   <= phase_d;
            col_q     <= col_d;
            led_off_q <= led_off_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign led_off  = led_off_q;
    assign redled   = red_q;
    assign greenled = green_q;
    assign blueled  = blue_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized scoreboard bench for blink_sequencer.
// Reference model works from sample windows and elapsed time.
module tb_blink_sequencer;

    localparam int D = 4;
    localparam int H = 8;

    typedef struct packed {
        logic       lo;
        logic       r;
        logic       g;
        logic       b;
        logic [1:0] m;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       led_off;
    logic       redled;
    logic       greenled;
    logic       blueled;
    logic [1:0] mode;

    int tests = 0;
    int fails = 0;
    obs_t sb[$];

    blink_sequencer #(
        .DEBOUNCE_CYC   (D),
        .HALF_PERIOD_CYC(H)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .led_off (led_off),
        .redled  (redled),
        .greenled(greenled),
        .blueled (blueled),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    function automatic obs_t expect_out(input int m, input int t);
        obs_t o;
        int   ph;
        int   c;
        ph = (t / H) % 2;
        c  = (t / H) % 3;
        o  = '0;
        o.m = 2'(m);
        case (m)
            0: o.lo = 1'b1;
            1: o.b = 1'b1;
            2: begin
                o.lo = (ph == 1);
                o.b  = (ph == 0);
            end
            default: begin
                o.r = (c == 0);
                o.g = (c == 1);
                o.b = (c == 2);
            end
        endcase
        return o;
    endfunction

    // Model: a level is accepted once D consecutive samples, seen
    // two edges late through the synchronizer, all differ from it.
    initial begin
        bit hist[$];
        bit deb;
        bit pend;
        bit all;
        int m;
        int t;
        deb = 0; pend = 0; m = 0; t = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                hist.delete();
                repeat (D + 2) hist.push_back(1'b0);
                deb = 0; pend = 0; m = 0; t = 0;
            end else begin
                if (pend) begin
                    m = (m + 1) % 4;
                    t = 0;
                end else begin
                    t++;
                end
                pend = 0;
                hist.push_back(btn);
                void'(hist.pop_front());
                all = 1;
                for (int i = 0; i < D; i++) if (hist[i] == deb) all = 0;
                if (all) begin
                    deb = !deb;
                    if (deb) pend = 1;
                end
            end
            sb.push_back(expect_out(m, t));
        end
    end

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {led_off, redled, greenled, blueled, mode};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t got lo/r/g/b/mode=%b want %b",
                             $time, a, e);
                end
                if (mode == 2'd3) begin
                    tests++;
                    if (!$onehot({redled, greenled, blueled})) begin
                        fails++;
                        $display("FAIL onehot t=%0t got rgb=%b want one bit",
                                 $time, {redled, greenled, blueled});
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        btn = 1'b1;
        cyc(hold);
        btn = 1'b0;
        cyc(gap);
    endtask

    task automatic check_latency();
        int k;
        bit seen;
        k = 0;
        seen = 0;
        @(negedge clk);
        btn = 1'b1;
        while (!seen && k < 30) begin
            @(posedge clk);
            #1;
            k++;
            if (mode == 2'd1) seen = 1;
        end
        tests++;
        if (!seen || k != D + 3) begin
            fails++;
            $display("FAIL latency got %0d edges (seen=%0d) want %0d",
                     k, seen, D + 3);
        end
        cyc(13);
        btn = 1'b0;
        cyc(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(5);
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            cyc(2);
        end
        btn = 1'b0;
        cyc(10);
        check_latency();
        press(10, 10);
        cyc(40);
        press(10, 10);
        cyc(60);
        press(10, 10);
        press(10, 10);
        press(10, 10);
        cyc(10);
        btn = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(15);
        btn = 1'b0;
        cyc(12);
        for (int s = 0; s < 250; s++) begin
            btn = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 10));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
        end
        btn = 1'b0;
        cyc(30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 240000, consecutive stable cycles required to accept a button level (20 ms at 12 MHz).
REQ-002 Parameter HALF_PERIOD_CYC, default 6000000, cycles per blink phase (0.5 s at 12 MHz).
REQ-003 Port clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btn  input  1  raw, asynchronous, bouncing push-button (1 = pressed).
REQ-006 Port led_off  output  1  control for the downstream LED stage's reset input (1 = LED dark, 0 = LED lit).
REQ-007 Port redled, greenled, blueled  output  1 each  direct colour enables (1 = on).
REQ-008 Port mode  output  2  current mode code: OFF=0, SOLID=1, BLINK=2, CYCLE=3.

Function
REQ-009 btn shall pass through a 2-flop synchronizer before any other use.
REQ-010 Debouncer: the counter increments each cycle the synchronized level differs from the debounced level, and clears to 0 when they match (any bounce restarts the count).
REQ-011 The debounced level shall take the synchronized value on the cycle the count would reach DEBOUNCE_CYC; the counter then clears.
REQ-012 A debounced 0->1 transition shall generate exactly one single-cycle press pulse; releases generate nothing.
REQ-013 Mode FSM on press: OFF->SOLID->BLINK->CYCLE->OFF; with no press, the mode holds.
REQ-014 mode and all LED outputs shall update exactly DEBOUNCE_CYC+3 rising edges after the first edge that samples btn=1, assuming btn stays stable.
REQ-015 Phase counter: counts 0..HALF_PERIOD_CYC-1, wraps to 0, and toggles phase at the wrap; counter and phase clear to 0 on every mode change.
REQ-016 Colour index (0=R, 1=G, 2=B) advances at each phase wrap in CYCLE only, wraps 2->0, and clears to 0 on mode change.
REQ-017 OFF: led_off=1, all colour outputs 0.
REQ-018 SOLID: led_off=0, blueled=1, red/green 0.
REQ-019 BLINK: led_off=phase, blueled=~phase, red/green 0.
REQ-020 CYCLE: led_off=0; exactly one colour is 1, selected by the colour index.
REQ-021 All outputs shall be registered, with no combinational path from btn to any output.
REQ-022 A press that coincides with a phase wrap shall take priority: the counters clear and the mode advances.
REQ-023 Holding btn indefinitely shall yield exactly one mode step; another step requires a release accepted by the debouncer, then a new press.

Reset
REQ-024 While reset=1 at a clock edge, all state shall clear: mode=OFF, counters=0, phase=0, colour=0, debounced level=0, synchronizer=0.
REQ-025 Reset outputs: led_off=1, redled=greenled=blueled=0, mode=0; these are visible on the edge after reset is sampled.
REQ-026 Reset asserted mid-debounce or mid-phase shall discard the partial count; a button still held after reset release counts as a new press once debounced.

Structure
REQ-027 A shared package blink_pkg shall hold the mode enum (OFF/SOLID/BLINK/CYCLE), the colour-index constants, and the default parameter values.
REQ-028 The synchronizer and debouncer shall form one sub-module, btn_debounce (ports clk, reset, btn, press); the FSM, phase counter and output register stay in blink_sequencer.
REQ-029 Counter widths shall be $clog2 of the respective parameter, with no truncation at the default values.

Verification (DEBOUNCE_CYC=4, HALF_PERIOD_CYC=8)
REQ-030 Reset held 3 cycles, btn=0 -> led_off=1, colours 0, mode=0 on every cycle thereafter.
REQ-031 btn rises and holds 20 cycles -> mode=1 and blueled=1, led_off=0 exactly 7 edges after first sample; no further change while held.
REQ-032 btn toggles every 2 cycles for 20 cycles, then 0 -> mode stays 0 throughout.
REQ-033 Two clean presses, mode=2 -> led_off sequence 0 x8, 1 x8, 0 x8, ... with blueled its complement.
REQ-034 Three presses, mode=3 -> colour sequence R x8, G x8, B x8, R; never more or fewer than one colour set at a time.
REQ-035 Reset asserted for 1 cycle mid-BLINK with btn held -> OFF outputs on the next edge; mode=1 follows 7 edges after reset deasserts.
